// File: rtl/msg_framer.sv
// Transmit framer: emits LEN, SEQ, fifo payload, CRC16 hi/lo and SYNC on a valid/ready byte stream.
// Define MSG_FRAMER_ELEMCNT_GATE_EN to hold a request until the fifo already holds the full payload.
module msg_framer #(
  parameter int unsigned MAX_PAYLOAD = 59,
  parameter logic [7:0]  SYNC_BYTE   = 8'h7E,
  parameter int unsigned CNT_WIDTH   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic [5:0]           frame_len,
  input  logic [3:0]           frame_seq,
  input  logic [7:0]           fifo_dout,
  input  logic                 fifo_empty,
  input  logic [CNT_WIDTH-1:0] fifo_elemcnt,
  output logic                 fifo_rd_en,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 len_err
);

  localparam logic [5:0] MaxLen = 6'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    StIdle, StLen, StSeq, StFetch, StSettle, StPay, StCrcH, StCrcL, StSync
  } state_e;

  state_e      state_q;
  logic [15:0] crc_q;
  logic [5:0]  rem_q;
  logic [3:0]  seq_q;
  logic [7:0]  out_data_q;
  logic        out_valid_q;
  logic        busy_q;
  logic        len_err_q;

  logic        hs;
  logic [15:0] crc_nxt;

  // Reflected CRC16 (poly 0x8408), one byte LSB-first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  assign hs         = out_valid_q && out_ready;
  assign crc_nxt    = crc_step(crc_q, out_data_q);
  assign fifo_rd_en = (state_q == StFetch) && !fifo_empty && !out_valid_q;
  assign frame_done = (state_q == StSync) && hs;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign len_err    = len_err_q;

`ifndef MSG_FRAMER_ELEMCNT_GATE_EN
  logic unused_elemcnt;
  assign unused_elemcnt = ^fifo_elemcnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      crc_q       <= 16'hFFFF;
      rem_q       <= '0;
      seq_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start && !busy_q) begin
            if (frame_len > MaxLen) begin
              len_err_q <= 1'b1;
            end else begin
              rem_q  <= frame_len;
              seq_q  <= frame_seq;
              crc_q  <= 16'hFFFF;
              busy_q <= 1'b1;
`ifndef MSG_FRAMER_ELEMCNT_GATE_EN
              out_data_q  <= {2'b00, frame_len} + 8'd5;
              out_valid_q <= 1'b1;
              state_q     <= StLen;
`endif
            end
          end
`ifdef MSG_FRAMER_ELEMCNT_GATE_EN
          // Pending request: start only once the whole payload is in the fifo.
          else if (busy_q && (fifo_elemcnt >= CNT_WIDTH'(rem_q))) begin
            out_data_q  <= {2'b00, rem_q} + 8'd5;
            out_valid_q <= 1'b1;
            state_q     <= StLen;
          end
`endif
        end
        StLen: begin
          if (hs) begin
            crc_q      <= crc_nxt;
            out_data_q <= {4'h1, seq_q};
            state_q    <= StSeq;
          end
        end
        StSeq: begin
          if (hs) begin
            crc_q <= crc_nxt;
            if (rem_q != 6'd0) begin
              out_valid_q <= 1'b0;
              state_q     <= StFetch;
            end else begin
              out_data_q <= crc_nxt[15:8];
              state_q    <= StCrcH;
            end
          end
        end
        StFetch: begin
          if (fifo_rd_en) begin
            out_data_q <= fifo_dout;
            state_q    <= StSettle;
          end
        end
        StSettle: begin
          out_valid_q <= 1'b1;
          state_q     <= StPay;
        end
        StPay: begin
          if (hs) begin
            crc_q <= crc_nxt;
            rem_q <= rem_q - 6'd1;
            if (rem_q != 6'd1) begin
              out_valid_q <= 1'b0;
              state_q     <= StFetch;
            end else begin
              out_data_q <= crc_nxt[15:8];
              state_q    <= StCrcH;
            end
          end
        end
        StCrcH: begin
          if (hs) begin
            out_data_q <= crc_q[7:0];
            state_q    <= StCrcL;
          end
        end
        StCrcL: begin
          if (hs) begin
            out_data_q <= SYNC_BYTE;
            state_q    <= StSync;
          end
        end
        StSync: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_framer.sv
// Randomised bench for msg_framer against a byte-queue frame model and a fifo model.
module tb_msg_framer;

  localparam int CntWidth = 9;

  logic                clk = 1'b0;
  logic                rst;
  logic                frame_start;
  logic [5:0]          frame_len;
  logic [3:0]          frame_seq;
  logic [7:0]          fifo_dout;
  logic                fifo_empty;
  logic [CntWidth-1:0] fifo_elemcnt;
  logic                fifo_rd_en;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                frame_done;
  logic                len_err;

  logic                wr_en;
  logic [7:0]          wr_data;
  bit                  rand_ready;

  logic [7:0] fifo_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0, rd_cnt = 0, rd_empty_cnt = 0, b2b_cnt = 0;
  int lerr_cnt = 0, valid_cnt = 0, stab_err = 0;
  logic       rd_prev = 1'b0, stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  msg_framer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_len    (frame_len),
    .frame_seq    (frame_seq),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_elemcnt (fifo_elemcnt),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  // Registered-output fifo: dout/empty/elemcnt reflect the queue after each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q.delete();
      fifo_dout    <= 8'h00;
      fifo_empty   <= 1'b1;
      fifo_elemcnt <= '0;
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (wr_en) fifo_q.push_back(wr_data);
      fifo_dout    <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      fifo_empty   <= (fifo_q.size() == 0);
      fifo_elemcnt <= CntWidth'(fifo_q.size());
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor sampled mid-cycle: values here are what the next rising edge sees.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) rx_q.push_back(out_data);
      if (fifo_rd_en) begin
        rd_cnt++;
        if (fifo_empty) rd_empty_cnt++;
        if (rd_prev) b2b_cnt++;
      end
      rd_prev = fifo_rd_en;
      if (frame_done) done_cnt++;
      if (len_err) lerr_cnt++;
      if (out_valid) valid_cnt++;
      if (stall_prev && (!out_valid || out_data != data_prev)) stab_err++;
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end else begin
      rd_prev    = 1'b0;
      stall_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reflected CRC: feedback of crc LSB against each data bit, LSB first.
  function automatic logic [15:0] crc16(input logic [7:0] bytes[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (bytes[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ bytes[i][b];
        c  = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic build_expected(input int len, input logic [3:0] seq, input logic [7:0] pl[$]);
    logic [15:0] c;
    exp_q.delete();
    exp_q.push_back(8'(len + 5));
    exp_q.push_back({4'h1, seq});
    foreach (pl[i]) exp_q.push_back(pl[i]);
    c = crc16(exp_q);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(8'h7E);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start(input logic [5:0] len, input logic [3:0] seq);
    frame_len   = len;
    frame_seq   = seq;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    end
  endtask

  task automatic send_frame(input string tag, input logic [5:0] len, input logic [3:0] seq,
                            input logic [7:0] pl[$], input bit rnd);
    int d0, r0, b0, e0, s0;
    foreach (pl[i]) push_byte(pl[i]);
    build_expected(int'(len), seq, pl);
    rx_q.delete();
    d0 = done_cnt; r0 = rd_cnt; b0 = b2b_cnt; e0 = rd_empty_cnt; s0 = stab_err;
    rand_ready = rnd;
    pulse_start(len, seq);
    wait_done(tag, 4000, d0);
    rand_ready = 1'b0;
    tick();
    tick();
    compare_frame(tag);
    check({tag, "_rd_cnt"}, rd_cnt - r0, int'(len));
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_rd_b2b"}, b2b_cnt - b0, 0);
    check({tag, "_rd_empty"}, rd_empty_cnt - e0, 0);
    check({tag, "_stable"}, stab_err - s0, 0);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] ref_vec[5];
    int d0, r0, l0, v0, exp_n, n;

    rst = 1'b1; frame_start = 1'b0; frame_len = '0; frame_seq = '0;
    wr_en = 1'b0; wr_data = '0; rand_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);

    // Model self-check against the published check value.
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    check("model_crc_123456789", crc16(pl), 16'h6F91);

    // Empty payload, against literal bytes as well as the model.
    pl.delete();
    send_frame("empty", 6'd0, 4'h0, pl, 1'b0);
    ref_vec = '{8'h05, 8'h10, 8'h9E, 8'h81, 8'h7E};
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check($sformatf("empty_literal%0d", i), rx_q[i], ref_vec[i]);

    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    send_frame("digits", 6'd9, 4'h3, pl, 1'b0);

    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
    send_frame("bp_ready1", 6'd4, 4'hA, pl, 1'b0);
    send_frame("bp_random", 6'd4, 4'hA, pl, 1'b1);

    for (int k = 0; k < 6; k++) begin
      logic [5:0] len;
      len = (k == 0) ? 6'd59 : 6'($urandom_range(1, 59));
      pl.delete();
      for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
      send_frame($sformatf("rand%0d", k), len, 4'($urandom), pl, 1'b1);
    end

    // Underrun: one byte present, the rest arrives much later.
    pl = '{8'hA1, 8'hB2, 8'hC3};
    push_byte(8'hA1);
    build_expected(3, 4'h5, pl);
    rx_q.delete();
    d0 = done_cnt; r0 = rd_cnt;
    pulse_start(6'd3, 4'h5);
    repeat (20) tick();
`ifdef MSG_FRAMER_ELEMCNT_GATE_EN
    exp_n = 0;
`else
    exp_n = 3;
`endif
    check("underrun_partial", rx_q.size(), exp_n);
    check("underrun_busy", busy, 1'b1);
    v0 = valid_cnt;
    repeat (30) tick();
    check("underrun_stall", valid_cnt - v0, 0);
    push_byte(8'hB2);
    push_byte(8'hC3);
    wait_done("underrun", 500, d0);
    tick();
    compare_frame("underrun");
    check("underrun_rd_cnt", rd_cnt - r0, 3);

    // Over-length request is rejected with no output.
    l0 = lerr_cnt; v0 = valid_cnt;
    pulse_start(6'd60, 4'h1);
    repeat (10) tick();
    check("lenerr_pulse", lerr_cnt - l0, 1);
    check("lenerr_busy", busy, 1'b0);
    check("lenerr_no_output", valid_cnt - v0, 0);

    // Requests while busy are ignored, including an over-length one.
    pl = '{8'h5A, 8'hC7};
    push_byte(8'h5A);
    push_byte(8'hC7);
    build_expected(2, 4'h6, pl);
    rx_q.delete();
    d0 = done_cnt; l0 = lerr_cnt;
    pulse_start(6'd2, 4'h6);
    repeat (2) tick();
    pulse_start(6'd5, 4'h9);
    pulse_start(6'd63, 4'h2);
    wait_done("overlap", 500, d0);
    repeat (10) tick();
    compare_frame("overlap");
    check("overlap_done_cnt", done_cnt - d0, 1);
    check("overlap_no_lenerr", lerr_cnt - l0, 0);
    check("overlap_busy", busy, 1'b0);

    // Reset mid-payload.
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    r0 = rd_cnt;
    pulse_start(6'd5, 4'h2);
    n = 0;
    while (rd_cnt - r0 < 2 && n < 200) begin
      tick();
      n++;
    end
    check("midrst_reached_payload", (rd_cnt - r0 >= 2), 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rd_en", fifo_rd_en, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    pl.delete();
    send_frame("post_rst", 6'd0, 4'h0, pl, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/msg_framer.md
Name: msg_framer

Overview:
- Transmit-side framing stage that sits directly downstream of the payload byte fifo (8-bit data).
- On a frame request it emits one complete frame on a valid/ready byte stream: length byte, sequence byte, payload drained from the fifo, CRC16 high byte, CRC16 low byte, sync byte.
- Its output feeds the serial transmitter.

Parameters:
- MAX_PAYLOAD, 59, largest accepted payload length in bytes; the total frame is at most MAX_PAYLOAD+5.
- SYNC_BYTE, 8'h7E, trailing sync byte value.
- CNT_WIDTH, 9, width of the fifo element count input (must match the fifo ADDR_WIDTH).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle request to send one frame; sampled only when busy=0
- frame_len  in  6  payload byte count (0..MAX_PAYLOAD), sampled with frame_start
- frame_seq  in  4  sequence number, sampled with frame_start
- fifo_dout  in  8  fifo read data (registered inside the fifo, one-cycle update after a read)
- fifo_empty  in  1  fifo empty flag (registered, aligned with fifo_dout)
- fifo_elemcnt  in  CNT_WIDTH  fifo fill level
- fifo_rd_en  out  1  fifo read strobe; the byte on fifo_dout is consumed in the same cycle
- out_data  out  8  framed byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse on the cycle the sync byte is accepted
- len_err  out  1  one-cycle pulse when a request is rejected for frame_len > MAX_PAYLOAD

Behaviour:
- Reset values (async assert, sync release): fifo_rd_en=0, out_valid=0, out_data=0, busy=0, frame_done=0, len_err=0, state=IDLE, crc=16'hFFFF.
- States: IDLE, LEN, SEQ, FETCH, SETTLE, PAY, CRCH, CRCL, SYNC.
- IDLE:
  - frame_start with frame_len <= MAX_PAYLOAD: latch len and seq, crc<=FFFF, busy<=1, go to LEN.
  - frame_start with frame_len > MAX_PAYLOAD: len_err pulse, stay in IDLE.
  - frame_start while busy=1: ignored, no error.
- LEN: out_data=frame_len+5, out_valid=1; on handshake fold the byte into the CRC and go to SEQ.
- SEQ: out_data={4'h1, seq}; on handshake fold into the CRC, then go to FETCH if len>0, else CRCH.
- FETCH:
  - Waits for fifo_empty=0 and no pending output byte.
  - Asserts fifo_rd_en for exactly one cycle and captures fifo_dout into the holding register in that cycle.
  - Goes to SETTLE.
- SETTLE: one idle cycle, so the fifo's registered dout/empty reflect the advanced pointer. The fifo is never strobed on consecutive cycles.
- PAY: present the held byte; on handshake fold it into the CRC and decrement the remaining count. Go to FETCH if bytes remain, else CRCH.
- fifo_rd_en is never asserted while fifo_empty=1, and never outside FETCH.
- CRC:
  - Reflected CRC16, poly 16'h8408, init 16'hFFFF, no final xor, LSB-first, 8 bits per handshake, one cycle.
  - Covers the length byte, sequence byte and payload.
- CRCH sends crc[15:8]; CRCL sends crc[7:0]; SYNC sends SYNC_BYTE.
- On the SYNC handshake: frame_done pulse, busy<=0, return to IDLE.
- A new frame_start is accepted the cycle after frame_done.
- Output stability: while out_valid && !out_ready, out_data is held constant and out_valid stays high. out_valid may be continuous across bytes except around payload fetches.
- Throughput:
  - Header and trailer bytes: up to 1 byte/clk.
  - Payload: at most 1 byte per 3 clk (FETCH, SETTLE, PAY).
- Fifo underrun mid-frame: stall in FETCH indefinitely with no output; the frame resumes when data arrives and no bytes are dropped.
- Reset mid-frame: immediate return to IDLE with outputs at reset values. Fifo contents already read are lost; no partial-frame recovery.

Optional Feature:
- Macro: MSG_FRAMER_ELEMCNT_GATE_EN.
- Defined:
  - IDLE additionally requires fifo_elemcnt >= frame_len before leaving for LEN.
  - The request is held pending (busy=1, no output) until the condition holds, so a frame never stalls mid-payload.
  - A fifo_elemcnt wrap is not considered; the fifo never holds more than 2^CNT_WIDTH-1 entries.
- Not defined: fifo_elemcnt is unused, the frame starts immediately, and underrun stalls in FETCH.

Test Plan:
- Empty payload: frame_len=0, seq=0, out_ready=1 -> bytes 05 10 9E 81 7E; frame_done once; fifo_rd_en never high.
- Payload "123456789": fifo preloaded, frame_len=9, seq=3 -> 0E 13 31..39, CRC matching the bench model (model self-check: CRC of "123456789" alone = 0x6F91), then 7E; fifo_rd_en count = 9 with no back-to-back strobes.
- Backpressure: frame_len=4, out_ready toggled randomly -> out_data stable while stalled; byte sequence identical to the out_ready=1 run.
- Underrun: frame_len=3 with only 1 byte in the fifo, 2nd byte written 50 cycles later -> stall in FETCH, no out_valid; frame completes correctly (with MSG_FRAMER_ELEMCNT_GATE_EN: no LEN byte before elemcnt>=3).
- Errors/overlap: frame_len=60 -> len_err pulse, no output; frame_start during busy -> ignored; rst asserted mid-payload -> out_valid=0, busy=0 immediately.
